// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave):
// instruction fields and ALU flag in, every enable/mux select out.
interface mc_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_ctrl;
    logic [1:0]         pc_source;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, illegal, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM: Moore decode of state, memory wait counter and latched op/funct.
// Optional macro MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mc_control_fsm #(
    parameter int MEM_LAT = 1,
    parameter int STATE_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mc_ctrl_if.master   bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_LOAD_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_I_EXEC    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

    // Returns {valid, alu_ctrl} for an R-type funct field.
    function automatic logic [3:0] funct_decode(input logic [5:0] f);
        case (f)
            6'h20:   return {1'b1, ALU_ADD};
            6'h22:   return {1'b1, ALU_SUB};
            6'h24:   return {1'b1, ALU_AND};
            6'h25:   return {1'b1, ALU_OR};
            6'h2A:   return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

    logic [3:0] state_r;
    logic [3:0] next_s;
    logic [3:0] wait_r;
    logic [5:0] op_r;
    logic [5:0] funct_r;
    logic       mem_done_s;
    logic [3:0] r_dec_s;

    assign mem_done_s = (wait_r == WAIT_LAST);
    assign r_dec_s    = funct_decode(funct_r);

    // Next-state selection; memory states dwell until the wait counter expires.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:     next_s = mem_done_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     next_s = S_R_EXEC;
                    OP_LW, OP_SW: next_s = S_MEM_ADDR;
                    OP_BEQ:       next_s = S_BRANCH;
                    OP_J:         next_s = S_JUMP;
                    OP_ADDI:      next_s = S_I_EXEC;
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  next_s = (op_r == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_s = mem_done_s ? S_LOAD_WB : S_MEM_READ;
            S_MEM_WRITE: next_s = mem_done_s ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    next_s = r_dec_s[3] ? S_R_WB : S_FETCH;
            S_I_EXEC:    next_s = S_I_WB;
            default:     next_s = S_FETCH;
        endcase
    end

    // State, wait counter and the op/funct captured in DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            wait_r  <= 4'd0;
            op_r    <= 6'd0;
            funct_r <= 6'd0;
        end else begin
            state_r <= next_s;
            wait_r  <= (next_s != state_r) ? 4'd0 : wait_r + 4'd1;
            if (state_r == S_DECODE) begin
                op_r    <= bus.opcode;
                funct_r <= bus.funct;
            end else begin
                op_r    <= op_r;
                funct_r <= funct_r;
            end
        end
    end

    logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
    logic       mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s, illegal_s;
    logic [1:0] alu_src_b_s, pc_source_s;
    logic [2:0] alu_ctrl_s;

    // Moore control decode; anything a state does not name stays 0.
    always_comb begin
        pc_write_s = 1'b0; pc_write_cond_s = 1'b0; i_or_d_s = 1'b0; mem_read_s = 1'b0;
        mem_write_s = 1'b0; ir_write_s = 1'b0; mem_to_reg_s = 1'b0; reg_dst_s = 1'b0;
        reg_write_s = 1'b0; alu_src_a_s = 1'b0; illegal_s = 1'b0;
        alu_src_b_s = 2'b00; pc_source_s = 2'b00; alu_ctrl_s = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_done_s;
                pc_write_s  = mem_done_s;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_s = 1'b0;
                    default:                                       illegal_s = 1'b1;
                endcase
            end
            S_MEM_ADDR:  begin alu_src_a_s = 1'b1; alu_src_b_s = 2'b10; end
            S_MEM_READ:  begin mem_read_s = 1'b1; i_or_d_s = 1'b1; end
            S_LOAD_WB:   begin reg_write_s = 1'b1; mem_to_reg_s = 1'b1; end
            S_MEM_WRITE: begin mem_write_s = 1'b1; i_or_d_s = 1'b1; end
            S_R_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = r_dec_s[2:0];
                illegal_s   = ~r_dec_s[3];
            end
            S_R_WB:      begin reg_write_s = 1'b1; reg_dst_s = 1'b1; end
            S_BRANCH: begin
                alu_src_a_s = 1'b1; alu_ctrl_s = ALU_SUB;
                pc_write_cond_s = 1'b1; pc_source_s = 2'b01;
            end
            S_JUMP:      begin pc_write_s = 1'b1; pc_source_s = 2'b10; end
            S_I_EXEC:    begin alu_src_a_s = 1'b1; alu_src_b_s = 2'b10; end
            S_I_WB:      reg_write_s = 1'b1;
            default:     illegal_s = 1'b0;
        endcase
    end

    // Reset forces every output low even before the first reset edge lands.
    assign bus.pc_write      = rst_n & pc_write_s;
    assign bus.pc_write_cond = rst_n & pc_write_cond_s;
    assign bus.i_or_d        = rst_n & i_or_d_s;
    assign bus.mem_read      = rst_n & mem_read_s;
    assign bus.mem_write     = rst_n & mem_write_s;
    assign bus.ir_write      = rst_n & ir_write_s;
    assign bus.mem_to_reg    = rst_n & mem_to_reg_s;
    assign bus.reg_dst       = rst_n & reg_dst_s;
    assign bus.reg_write     = rst_n & reg_write_s;
    assign bus.alu_src_a     = rst_n & alu_src_a_s;
    assign bus.illegal       = rst_n & illegal_s;
    assign bus.alu_src_b     = rst_n ? alu_src_b_s : 2'b00;
    assign bus.alu_ctrl      = rst_n ? alu_ctrl_s : 3'b000;
    assign bus.pc_source     = rst_n ? pc_source_s : 2'b00;
    assign bus.state         = rst_n ? STATE_W'(state_r) : {STATE_W{1'b0}};

`ifdef MC_PERF_CNT_EN
    logic instr_done_s;
    assign instr_done_s = (next_s == S_FETCH) &&
                          (state_r inside {S_R_WB, S_LOAD_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_I_WB});

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done_s) begin
                instr_cnt <= instr_cnt + 32'd1;
            end else begin
                instr_cnt <= instr_cnt;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (MEM_LAT=1 and 3) checked cycle by cycle against
// a per-instruction expected control-sequence model; random and directed instruction streams.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         icnt = 0;
    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    mc_ctrl_if #(.STATE_W(4)) bus1();
    mc_ctrl_if #(.STATE_W(4)) bus3();
    assign bus1.opcode = opcode; assign bus1.funct = funct; assign bus1.zero = zero;
    assign bus3.opcode = opcode; assign bus3.funct = funct; assign bus3.zero = zero;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc1, ins1, cyc3, ins3;
`endif

    mc_control_fsm #(.MEM_LAT(1), .STATE_W(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cyc1), .instr_cnt(ins1)
`endif
    );

    mc_control_fsm #(.MEM_LAT(3), .STATE_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cyc3), .instr_cnt(ins3)
`endif
    );

    // flag bits: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write}
    localparam logic [8:0] F_PCW  = 9'b100000000;
    localparam logic [8:0] F_PCWC = 9'b010000000;
    localparam logic [8:0] F_IORD = 9'b001000000;
    localparam logic [8:0] F_MR   = 9'b000100000;
    localparam logic [8:0] F_MW   = 9'b000010000;
    localparam logic [8:0] F_IRW  = 9'b000001000;
    localparam logic [8:0] F_M2R  = 9'b000000100;
    localparam logic [8:0] F_RDST = 9'b000000010;
    localparam logic [8:0] F_RW   = 9'b000000001;

    function automatic logic [21:0] cv(input logic [3:0] st, input logic [8:0] fl, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic ill);
        return {st, fl, asa, asb, alu, pcs, ill};
    endfunction

    function automatic logic [21:0] obs(input int sel);
        if (sel == 3)
            return {bus3.state, bus3.pc_write, bus3.pc_write_cond, bus3.i_or_d, bus3.mem_read,
                    bus3.mem_write, bus3.ir_write, bus3.mem_to_reg, bus3.reg_dst, bus3.reg_write,
                    bus3.alu_src_a, bus3.alu_src_b, bus3.alu_ctrl, bus3.pc_source, bus3.illegal};
        else
            return {bus1.state, bus1.pc_write, bus1.pc_write_cond, bus1.i_or_d, bus1.mem_read,
                    bus1.mem_write, bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write,
                    bus1.alu_src_a, bus1.alu_src_b, bus1.alu_ctrl, bus1.pc_source, bus1.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit r_alu(input logic [5:0] fn, output logic [2:0] alu);
        alu = 3'b000;
        case (fn)
            6'h20: begin alu = 3'b000; return 1'b1; end
            6'h22: begin alu = 3'b001; return 1'b1; end
            6'h24: begin alu = 3'b010; return 1'b1; end
            6'h25: begin alu = 3'b011; return 1'b1; end
            6'h2A: begin alu = 3'b100; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle control sequence for one instruction; returns 1 if it retires.
    function automatic bit build_expect(input logic [5:0] op, input logic [5:0] fn, input int lat);
        logic [2:0] alu;
        bit ok;
        bit legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
                    (op == 6'h02) || (op == 6'h08);
        exp_q.delete();
        for (int i = 0; i < lat; i++)
            exp_q.push_back(cv(4'd0, F_MR | ((i == lat - 1) ? (F_IRW | F_PCW) : 9'd0),
                               1'b0, 2'b01, 3'b000, 2'b00, 1'b0));
        exp_q.push_back(cv(4'd1, 9'd0, 1'b0, 2'b11, 3'b000, 2'b00, !legal));
        if (!legal) return 1'b0;
        case (op)
            6'h00: begin
                ok = r_alu(fn, alu);
                exp_q.push_back(cv(4'd6, 9'd0, 1'b1, 2'b00, alu, 2'b00, !ok));
                if (!ok) return 1'b0;
                exp_q.push_back(cv(4'd7, F_RW | F_RDST, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0));
            end
            6'h23: begin
                exp_q.push_back(cv(4'd2, 9'd0, 1'b1, 2'b10, 3'b000, 2'b00, 1'b0));
                for (int i = 0; i < lat; i++)
                    exp_q.push_back(cv(4'd3, F_MR | F_IORD, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0));
                exp_q.push_back(cv(4'd4, F_RW | F_M2R, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0));
            end
            6'h2B: begin
                exp_q.push_back(cv(4'd2, 9'd0, 1'b1, 2'b10, 3'b000, 2'b00, 1'b0));
                for (int i = 0; i < lat; i++)
                    exp_q.push_back(cv(4'd5, F_MW | F_IORD, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0));
            end
            6'h04: exp_q.push_back(cv(4'd8, F_PCWC, 1'b1, 2'b00, 3'b001, 2'b01, 1'b0));
            6'h02: exp_q.push_back(cv(4'd9, F_PCW, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0));
            default: begin
                exp_q.push_back(cv(4'd10, 9'd0, 1'b1, 2'b10, 3'b000, 2'b00, 1'b0));
                exp_q.push_back(cv(4'd11, F_RW, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0));
            end
        endcase
        return 1'b1;
    endfunction

    // Entered at a negedge in the first FETCH cycle; leaves at the next FETCH negedge.
    task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int abort_at, input string name);
        int lat = (sel == 3) ? 3 : 1;
        bit retires;
        opcode = op; funct = fn; zero = z;
        retires = build_expect(op, fn, lat);
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            check($sformatf("%s_lat%0d_c%0d", name, lat, i), 32'(obs(sel)), 32'(exp_q[i]));
`ifdef MC_PERF_CNT_EN
            check($sformatf("%s_cyccnt_c%0d", name, i), (sel == 3) ? cyc3 : cyc1, 32'(cyc));
`endif
            if (i == abort_at) return;
            if (exp_q[i][21:18] >= 4'd2) begin
                opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        if (retires) icnt++;
`ifdef MC_PERF_CNT_EN
        #1;
        check($sformatf("%s_instrcnt", name), (sel == 3) ? ins3 : ins1, 32'(icnt));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gate_l1", 32'(obs(1)), 32'd0);
        check("rst_gate_l3", 32'(obs(3)), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_hold_l1", 32'(obs(1)), 32'd0);
            check("rst_hold_l3", 32'(obs(3)), 32'd0);
`ifdef MC_PERF_CNT_EN
            check("rst_cnt_l3", cyc3 | ins3, 32'd0);
            check("rst_cnt_l1", cyc1 | ins1, 32'd0);
`endif
        end
        rst_n = 1'b1;
        cyc = 0;
        icnt = 0;
    endtask

    task automatic random_block(input int sel, input int n);
        logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] op, fn;
        for (int k = 0; k < n; k++) begin
            op = ($urandom_range(0, 6) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(sel, op, fn, 1'($urandom), -1, "rnd");
        end
    endtask

    initial begin
        do_reset();
        run_instr(1, 6'h00, 6'h20, 1'b0, -1, "add");
        run_instr(1, 6'h04, 6'h00, 1'b1, -1, "beq_z1");
        run_instr(1, 6'h04, 6'h00, 1'b0, -1, "beq_z0");
        run_instr(1, 6'h3F, 6'h20, 1'b0, -1, "ill_op");
        run_instr(1, 6'h00, 6'h00, 1'b0, -1, "ill_fn");
        run_instr(1, 6'h02, 6'h00, 1'b0, -1, "j");
        run_instr(1, 6'h08, 6'h00, 1'b0, -1, "addi");
        run_instr(1, 6'h2B, 6'h00, 1'b0, -1, "sw");
        run_instr(1, 6'h23, 6'h00, 1'b0, -1, "lw");
        random_block(1, 25);

        do_reset();
        run_instr(3, 6'h23, 6'h00, 1'b0, -1, "lw");
        run_instr(3, 6'h2B, 6'h00, 1'b0, -1, "sw");
        random_block(3, 25);
        run_instr(3, 6'h2B, 6'h00, 1'b0, 5, "sw_abort");
        do_reset();
        run_instr(3, 6'h00, 6'h2A, 1'b0, -1, "slt_after_rst");
        run_instr(3, 6'h00, 6'h24, 1'b0, -1, "and");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the MIPS-subset CPU.
- Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select.
- Sits directly upstream of the register file: its reg_write, reg_dst and mem_to_reg outputs form the register file's wEna and select its wAddr/wDin sources.
- Consumes opcode/funct from the instruction register and the ALU zero flag.

Parameters:
- MEM_LAT, 1, cycles each memory access (fetch/load/store) is held; legal range 1..15.
- STATE_W, 4, width of state/debug output.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, valid in BRANCH state
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero (beq)
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  reg wDin: 0=ALUOut, 1=MDR
- reg_dst  output  1  reg wAddr: 0=rt, 1=rd
- reg_write  output  1  register file wEna
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
- alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal  output  1  one-cycle pulse: undecodable opcode/funct
- state  output  STATE_W  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, LOAD_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Outputs are Moore decode of state, wait counter, and the op/funct latched in DECODE.
- Reset: on a posedge with rst_n=0, state=FETCH and wait counter=0, regardless of the current state (abandons the instruction mid-flight). All outputs are forced 0 while rst_n=0, including mem_read and illegal.
- Wait counter: in FETCH, MEM_READ and MEM_WRITE, the strobe is held for MEM_LAT cycles.
  - Counter increments each cycle; state advances when counter==MEM_LAT-1.
  - Counter clears on each state change.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00.
  - ir_write and pc_write assert only on the final wait cycle.
  - Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target precompute); latch opcode/funct. Next state by opcode:
  - 0x00 -> R_EXEC
  - 0x23/0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> I_EXEC
  - else -> FETCH with illegal=1 for this cycle
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Unknown funct: illegal=1, next state FETCH, no write-back.
  - Otherwise next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1 -> LOAD_WB.
- LOAD_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, add -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Exclusivity and mid-instruction inputs:
  - reg_write, mem_write and ir_write are mutually exclusive, never high in the same cycle.
  - opcode changes after DECODE have no effect.
- Cycle counts with MEM_LAT=1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
  - Each memory state adds MEM_LAT-1 cycles.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from a completing state (R_WB, LOAD_WB, MEM_WRITE, BRANCH, JUMP, I_WB); illegal instructions are not counted.
  - Both counters wrap at 2^32.
- Undefined: no ports and no logic for these counters.

Test Plan:
- Reset held 2 cycles, released -> state=0, all outputs 0 during reset; first cycle after release mem_read=1, ir_write=1, pc_write=1.
- add (op 0x00, funct 0x20), MEM_LAT=1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in state 7.
- lw (0x23) with MEM_LAT=3 -> FETCH 3 cycles, MEM_READ 3 cycles, 9 cycles total; reg_write=1 with mem_to_reg=1 in LOAD_WB.
- beq (0x04) with zero=1, then with zero=0 -> BRANCH asserts pc_write_cond=1, pc_source=01 in both cases; 3 cycles each.
- opcode 0x3F, then R-type with funct 0x00 -> illegal pulses for 1 cycle (in DECODE, then in R_EXEC); no reg_write; return to FETCH.
- rst_n=0 during MEM_WRITE of sw -> next cycle state=FETCH, mem_write=0; with MC_PERF_CNT_EN, both counters read 0.
